// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module   : im_loader
//  Purpose  : Boot loader. Receives a 16-bit word count and then program
//             bytes from a byte stream (MSB first). It packs them into 32-bit
//             words and writes them to instruction memory starting at
//             BASE_ADDR. The processor is held in reset until a load
//             finishes successfully.
//  Ports    : clk, rst_f (async, active-high)
//             start                        - one-cycle load request
//             rx_data/rx_valid/rx_ready    - byte stream handshake
//             im_we/im_addr/im_wdata       - instruction-memory write port
//             cpu_hold                     - processor reset hold
//             busy/done/err                - load status
//  Revision : 1.0  initial release
// ============================================================================
module im_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd1024
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        im_we,
   output logic [15:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  byte_cnt;
   logic [15:0] word_cnt;
   logic [15:0] len_reg;
   // Only the first three bytes of a word need storage; the fourth byte is
   // merged directly into im_wdata as it arrives.
   logic [23:0] word_reg;

   logic [15:0] len_full;
   logic [15:0] word_cnt_inc;

   assign len_full     = {len_reg[7:0], rx_data};
   assign word_cnt_inc = word_cnt + 16'd1;

   // State register
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and Moore outputs
   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      im_we     = 1'b0;
      cpu_hold  = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN;
         end
         S_LEN: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid && byte_cnt == 2'd1) begin
               if (len_full == 16'd0 || len_full > MAX_WORDS) state_nxt = S_ERR;
               else                                           state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            im_we = 1'b1;
            busy  = 1'b1;
            state_nxt = (word_cnt_inc == len_reg) ? S_DONE : S_DATA;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nxt = S_LEN;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_nxt = S_LEN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath. rx_ready is 1 exactly in LEN and DATA, so rx_valid alone
   // marks a transfer inside those branches.
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         byte_cnt <= 2'd0;
         word_cnt <= 16'd0;
         len_reg  <= 16'd0;
         word_reg <= 24'd0;
         im_addr  <= 16'd0;
         im_wdata <= 32'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  byte_cnt <= 2'd0;
                  word_cnt <= 16'd0;
                  len_reg  <= 16'd0;
               end
            end
            S_LEN: begin
               if (rx_valid) begin
                  len_reg  <= len_full;
                  // Restart at zero so DATA begins counting a fresh word.
                  byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : 2'd1;
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  word_reg <= {word_reg[15:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  // Present the completed word and address during WRITE;
                  // both then hold until the next word completes.
                  if (byte_cnt == 2'd3) begin
                     im_wdata <= {word_reg, rx_data};
                     im_addr  <= BASE_ADDR + word_cnt;
                  end
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_im_loader
//  Purpose  : Directed self-checking bench for im_loader. Two instances
//             share one byte stream: u_dut0 uses default parameters,
//             u_dut1 uses BASE_ADDR=FFFF and MAX_WORDS=2 to exercise
//             address wrap and the length upper bound.
//  Revision : 1.0  initial release
// ============================================================================
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        rdy0, we0, hold0, busy0, done0, err0;
   logic [15:0] addr0;
   logic [31:0] wd0;
   logic        rdy1, we1, hold1, busy1, done1, err1;
   logic [15:0] addr1;
   logic [31:0] wd1;

   im_loader u_dut0 (
      .clk(clk), .rst_f(rst_f), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rdy0), .im_we(we0), .im_addr(addr0),
      .im_wdata(wd0), .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
   );

   im_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(16'd2)) u_dut1 (
      .clk(clk), .rst_f(rst_f), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rdy1), .im_we(we1), .im_addr(addr1),
      .im_wdata(wd1), .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int t0       = 0;
   int lat      = 0;

   logic [15:0] wa0[$];
   logic [31:0] wdq0[$];
   logic [15:0] wa1[$];
   logic [31:0] wdq1[$];
   logic [7:0]  bq[$];

   // Write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (we0) begin wa0.push_back(addr0); wdq0.push_back(wd0); end
      if (we1) begin wa1.push_back(addr1); wdq1.push_back(wd1); end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      wa0.delete(); wdq0.delete(); wa1.delete(); wdq1.delete();
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      t0    = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Presents one byte after 'gap' idle cycles; returns just after the
   // rising edge that transfers it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'hA5;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rdy0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check_val("send_timeout", 32'd0, 32'd1);
      else @(posedge clk);
   endtask

   task automatic send_list(input int gap);
      foreach (bq[i]) send_byte(bq[i], gap);
   endtask

   // Waits for DONE or ERR on u_dut0; lat = edges from the start edge.
   task automatic wait_end(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      rx_valid = 1'b0;
      while (!(done0 || err0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check_val({tag, "_timeout"}, 32'd0, 32'd1);
      lat = cyc - t0 - 1;
   endtask

   initial begin
      rst_f    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      // Reset values before any clock edge
      #2;
      check_val("rst_hold",   32'(hold0), 32'd1);
      check_val("rst_ready",  32'(rdy0),  32'd0);
      check_val("rst_we",     32'(we0),   32'd0);
      check_val("rst_busy",   32'(busy0), 32'd0);
      check_val("rst_done",   32'(done0), 32'd0);
      check_val("rst_err",    32'(err0),  32'd0);
      check_val("rst_addr",   32'(addr0), 32'd0);
      check_val("rst_wdata",  wd0,        32'd0);
      repeat (2) @(negedge clk);
      rst_f = 1'b0;

      // Two-word load, continuous stream
      clear_q();
      do_start();
      bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      send_list(0);
      wait_end("t1");
      check_val("t1_latency", 32'(lat),       32'd12);
      check_val("t1_done",    32'(done0),     32'd1);
      check_val("t1_hold",    32'(hold0),     32'd0);
      check_val("t1_busy",    32'(busy0),     32'd0);
      check_val("t1_nwr",     32'(wa0.size()), 32'd2);
      check_val("t1_a0",      32'(wa0[0]),    32'h0000);
      check_val("t1_d0",      wdq0[0],        32'h12345678);
      check_val("t1_a1",      32'(wa0[1]),    32'h0001);
      check_val("t1_d1",      wdq0[1],        32'h9ABCDEF0);
      check_val("t1_wrap_a0", 32'(wa1[0]),    32'hFFFF);
      check_val("t1_wrap_a1", 32'(wa1[1]),    32'h0000);
      check_val("t1_max_ok",  32'(done1),     32'd1);

      // Bytes offered in DONE are ignored
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      repeat (4) @(negedge clk);
      check_val("done_ready", 32'(rdy0),        32'd0);
      check_val("done_stay",  32'(done0),       32'd1);
      check_val("done_nwr",   32'(wa0.size()),  32'd2);
      check_val("done_addr",  32'(addr0),       32'h0001);
      rx_valid = 1'b0;

      // Restart from DONE, then async reset after two data bytes
      clear_q();
      do_start();
      check_val("rs_done_clr", 32'(done0), 32'd0);
      check_val("rs_hold",     32'(hold0), 32'd1);
      bq = '{8'h00, 8'h01, 8'h11, 8'h22};
      send_list(0);
      #3 rst_f = 1'b1;
      rx_valid = 1'b0;
      #1;
      check_val("ar_busy",  32'(busy0), 32'd0);
      check_val("ar_hold",  32'(hold0), 32'd1);
      check_val("ar_ready", 32'(rdy0),  32'd0);
      check_val("ar_addr",  32'(addr0), 32'd0);
      check_val("ar_wdata", wd0,        32'd0);
      @(negedge clk);
      rst_f = 1'b0;
      check_val("ar_nwr", 32'(wa0.size()), 32'd0);
      do_start();
      bq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_list(0);
      wait_end("t2");
      check_val("t2_nwr",   32'(wa0.size()), 32'd1);
      check_val("t2_a0",    32'(wa0[0]),    32'h0000);
      check_val("t2_d0",    wdq0[0],        32'hDEADBEEF);
      check_val("t2_base1", 32'(wa1[0]),    32'hFFFF);

      // Zero length
      clear_q();
      do_start();
      bq = '{8'h00, 8'h00};
      send_list(0);
      wait_end("t3");
      check_val("len0_err",  32'(err0),        32'd1);
      check_val("len0_hold", 32'(hold0),       32'd1);
      check_val("len0_done", 32'(done0),       32'd0);
      check_val("len0_nwr",  32'(wa0.size()),  32'd0);
      do_start();
      bq = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      send_list(0);
      wait_end("t3b");
      check_val("rec_err",  32'(err0),  32'd0);
      check_val("rec_done", 32'(done0), 32'd1);
      check_val("rec_d0",   wdq0[0],    32'hA1B2C3D4);

      // Length 1025 > MAX_WORDS
      clear_q();
      do_start();
      bq = '{8'h04, 8'h01};
      send_list(0);
      @(negedge clk);
      rx_valid = 1'b0;
      check_val("big_err0", 32'(err0),       32'd1);
      check_val("big_err1", 32'(err1),       32'd1);
      check_val("big_busy", 32'(busy0),      32'd0);
      check_val("big_nwr",  32'(wa0.size()), 32'd0);

      // rx_valid toggling 1,0,0,1 with a start pulse mid-load
      clear_q();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 2);
      send_byte(8'hCA, 2);
      send_byte(8'hFE, 2);
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      check_val("tg_busy", 32'(busy0), 32'd1);
      send_byte(8'hF0, 2);
      send_byte(8'h0D, 2);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      check_val("tg_wr_ready", 32'(rdy0), 32'd0);
      check_val("tg_wr_we",    32'(we0),  32'd1);
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      check_val("tg_done", 32'(done0),       32'd1);
      check_val("tg_nwr",  32'(wa0.size()),  32'd1);
      check_val("tg_d0",   wdq0[0],          32'hCAFEF00D);

      // Length 3: legal for u_dut0, above MAX_WORDS=2 for u_dut1
      do_start();
      bq = '{8'h00, 8'h03};
      send_list(0);
      @(negedge clk);
      rx_valid = 1'b0;
      check_val("l3_busy0", 32'(busy0), 32'd1);
      check_val("l3_err0",  32'(err0),  32'd0);
      check_val("l3_err1",  32'(err1),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, first instruction-memory word address written.
REQ-002 Parameter MAX_WORDS, default 16'd1024, largest legal program length in words.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_f  input  1  asynchronous, active-high reset (1 = reset asserted).
REQ-005 start  input  1  single-cycle request to begin a load; sampled in IDLE, DONE and ERR only.
REQ-006 rx_data  input  8  serial program byte.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1 at a rising edge.
REQ-009 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  output  16  instruction-memory write address.
REQ-011 im_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the sisc processor in reset while 1.
REQ-013 busy  output  1  load in progress (LEN, DATA or WRITE state).
REQ-014 done  output  1  last load completed successfully.
REQ-015 err  output  1  last load aborted on an illegal length.

Function
REQ-016 The FSM SHALL have states IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-017 IDLE: when start=1, go to LEN and clear the byte counter, word counter and length register; otherwise stay.
REQ-018 LEN: rx_ready=1; accept two bytes, MSB first, into the 16-bit length register; after the 2nd byte go to ERR if length==0 or length>MAX_WORDS, else go to DATA.
REQ-019 DATA: rx_ready=1; shift each accepted byte into the word register MSB first (first byte lands in [31:24]); after the 4th byte of a word go to WRITE.
REQ-020 WRITE: exactly one cycle; rx_ready=0, im_we=1, im_addr=BASE_ADDR+word counter (16-bit wrap), im_wdata=assembled word.
REQ-021 After WRITE the word counter SHALL increment; go to DONE if the new count equals length, else go to DATA.
REQ-022 DONE: done=1, cpu_hold=0, rx_ready=0; start=1 returns to LEN (done cleared, cpu_hold=1 from the next cycle).
REQ-023 ERR: err=1, cpu_hold=1, rx_ready=0; start=1 returns to LEN with err cleared.
REQ-024 When start=1 in LEN, DATA or WRITE, it SHALL be ignored.
REQ-025 Bytes presented while rx_ready=0 SHALL NOT be consumed and SHALL NOT change any state.
REQ-026 rx_valid gaps of any length SHALL stall the load without loss or duplication.
REQ-027 im_we SHALL be 0 in every state except WRITE; im_addr and im_wdata SHALL hold their last values outside WRITE.
REQ-028 cpu_hold SHALL be 1 in every state except DONE.
REQ-029 busy SHALL be 1 exactly in LEN, DATA and WRITE.
REQ-030 Minimum load latency SHALL be 2 + 5*N cycles from the cycle after start to DONE, for N words with rx_valid held at 1.

Reset
REQ-031 While rst_f=1, regardless of clk, the FSM SHALL be forced to IDLE with all counters, the length register, the word register, im_addr and im_wdata at 0.
REQ-032 While rst_f=1, outputs SHALL be: cpu_hold=1, rx_ready=0, im_we=0, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-load SHALL abandon the load immediately, with no further im_we pulse; a partially assembled word is discarded.

Verification
REQ-034 Reset, then start; stream 00 02 12 34 56 78 9A BC DE F0 with rx_valid held at 1 -> two im_we pulses: addr 0000 data 12345678, then addr 0001 data 9ABCDEF0; done=1 and cpu_hold=0 twelve cycles after start.
REQ-035 Length bytes 00 00 -> ERR, err=1, cpu_hold=1, no im_we pulse; start, then a valid 1-word load -> err=0, done=1.
REQ-036 Length 04 01 with MAX_WORDS=1024 -> ERR after the 2nd length byte, no im_we pulse.
REQ-037 1-word load with rx_valid toggling 1,0,0,1,... -> one write with the correct word; no byte consumed while rx_ready=0 in WRITE.
REQ-038 rst_f pulsed asynchronously (between clock edges) after 2 data bytes -> outputs reach reset values without a clock edge; a subsequent start and full load writes from BASE_ADDR.
REQ-039 BASE_ADDR=16'hFFFF, 2-word load -> write addresses FFFF then 0000.
